// File: rtl/enc_pkg.sv
// Shared definitions for the sequential priority encoder: state encoding and
// the code-width helper.
package enc_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Pure combinational N-to-CW priority encoder; also reports the winning bit
// as a one-hot mask so the caller can clear it.
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MSB_FIRST = 1,
  localparam int unsigned CW       = clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [CW-1:0] code,
  output logic          any,
  output logic [N-1:0]  onehot_of_winner
);

  // Later loop iterations override earlier ones, so scan toward the winner.
  always_comb begin
    code             = '0;
    onehot_of_winner = '0;
    any              = |req;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req[i]) begin
          code                = CW'(i);
          onehot_of_winner    = '0;
          onehot_of_winner[i] = 1'b1;
        end
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (req[i]) begin
          code                = CW'(i);
          onehot_of_winner    = '0;
          onehot_of_winner[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/enc_4x2_pope_seq.sv
// Clocked 4-to-2 priority encoder: accepts a multi-hot request word and emits
// one index beat per set bit, highest priority first.
module enc_4x2_pope_seq
  import enc_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MSB_FIRST = 1,
  localparam int unsigned CW       = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_e,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] out_code,
  output logic          out_none,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  if (N < 2 || (N & (N - 1)) != 0) begin : gen_bad_n
    $error("N must be a power of 2 and at least 2");
  end

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic          none_q, none_d;

  logic [CW-1:0] win_code;
  logic          win_any;
  logic [N-1:0]  win_onehot;
  logic          last_beat;

  prio_enc_comb #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .req              (pending_q),
    .code             (win_code),
    .any              (win_any),
    .onehot_of_winner (win_onehot)
  );

  // Last beat when nothing remains once the current winner is cleared.
  assign last_beat = none_q | ~|(pending_q & ~win_onehot);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_code  = (out_valid && win_any) ? win_code : '0;
  assign out_none  = out_valid & none_q;
  assign out_last  = out_valid & last_beat;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;
    case (state_q)
      IDLE: begin
        // A word offered with in_e low is consumed and dropped.
        if (in_valid && in_e) begin
          pending_d = in_data;
          none_d    = (in_data == '0);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~win_onehot;
          if (last_beat) begin
            none_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

endmodule
